// File: rtl/sm_keypad_pkg.sv
// sm_keypad_pkg: shared FSM state, frame-result types and matrix constants
// for the keypad scanner.
package sm_keypad_pkg;

   localparam int COLS = 4;
   localparam int ROWS = 4;

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

   typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} fr_kind_t;

   typedef struct packed {
      fr_kind_t   kind;
      logic [3:0] key;
   } frame_t;

   localparam frame_t FRAME_NONE = '{kind: FR_NONE, key: 4'd0};

   // Fold one column's pressed-row bits into the running frame result.
   function automatic frame_t frame_merge(frame_t acc, logic [1:0] col, logic [ROWS-1:0] hit);
      frame_t     res;
      logic [2:0] n;
      logic [1:0] row;
      res = acc;
      n   = '0;
      row = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (hit[i]) begin
            n   = n + 3'd1;
            row = 2'(i);
         end
      end
      if (n != 3'd0) begin
         if (n > 3'd1 || acc.kind != FR_NONE) begin
            res.kind = FR_MULTI;
         end else begin
            res.kind = FR_SINGLE;
            res.key  = {col, row};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sm_keypad_scanner_sync.sv
// sm_sync2: two-flop synchronizer for asynchronous inputs; flops reset to all ones
// so idle (pulled-up) lines never look active coming out of reset.
module sm_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clkIn,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clkIn) begin
      if (rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sm_keypad_scanner.sv
// sm_keypad_scanner: 4x4 matrix keypad scanner with frame-level debounce.
// Optional auto-repeat while held is built only when SM_KEYPAD_REPEAT_EN is defined.
//
// state    | meaning
// IDLE     | no key accepted, waiting for a single-key frame
// DEBOUNCE | candidate key seen, counting identical frames
// HELD     | key accepted and still pressed
// RELEASE  | accepted key missing, counting frames before release
module sm_keypad_scanner
   import sm_keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 1024,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_RATE     = 16
) (
   input  logic       clkIn,
   input  logic       rst,
   output logic [3:0] col_n,
   input  logic [3:0] row_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam int DW_W  = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(DEBOUNCE_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("sm_keypad_scanner: parameter out of range");
   end

   logic [3:0]       row_s;
   logic [DW_W-1:0]  dwell;
   logic [1:0]       col;
   frame_t           acc;
   frame_t           fr;
   logic             last_dwell;
   logic             frame_end;
   logic             hit_cand;
   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [3:0]       cand;
   logic [3:0]       cand_nx;
   logic             accept;
   logic             rep_fire;

   sm_sync2 #(.WIDTH(ROWS)) u_sync (
      .clkIn (clkIn),
      .rst   (rst),
      .d     (row_n),
      .q     (row_s)
   );

   assign last_dwell = (dwell == DWELL_LAST);
   assign frame_end  = last_dwell && (col == 2'(COLS - 1));
   // fr already includes the column sampled this cycle, so at frame_end it is the whole frame
   assign fr         = frame_merge(acc, col, ~row_s);
   assign hit_cand   = (fr.kind == FR_SINGLE) && (fr.key == cand);

   always_ff @(posedge clkIn) begin
      if (rst) begin
         dwell <= '0;
         col   <= '0;
         acc   <= FRAME_NONE;
      end else if (last_dwell) begin
         dwell <= '0;
         col   <= col + 2'd1;
         acc   <= frame_end ? FRAME_NONE : fr;
      end else begin
         dwell <= dwell + DW_W'(1);
      end
   end

   always_comb begin
      col_n      = '1;
      col_n[col] = 1'b0;
   end

   always_ff @(posedge clkIn) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cand      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         cand      <= cand_nx;
         key_valid <= accept | rep_fire;
         if (accept) key_code <= cand_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cand_nx  = cand;
      accept   = 1'b0;
      if (frame_end) begin
         unique case (state)
            IDLE: begin
               if (fr.kind == FR_SINGLE) begin
                  cand_nx  = fr.key;
                  cnt_nx   = CNT_ONE;
                  state_nx = DEBOUNCE;
                  if (CNT_ONE == CNT_DONE) accept = 1'b1;
               end
            end
            DEBOUNCE: begin
               if (hit_cand) begin
                  cnt_nx = cnt + CNT_ONE;
                  if (cnt_nx == CNT_DONE) accept = 1'b1;
               end else if (fr.kind == FR_SINGLE) begin
                  cand_nx = fr.key;
                  cnt_nx  = CNT_ONE;
               end else begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end
            end
            HELD: begin
               if (!hit_cand) begin
                  state_nx = RELEASE;
                  cnt_nx   = CNT_ONE;
                  if (CNT_ONE == CNT_DONE) begin
                     state_nx = IDLE;
                     cnt_nx   = '0;
                  end
               end
            end
            RELEASE: begin
               if (hit_cand) begin
                  state_nx = HELD;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + CNT_ONE;
                  if (cnt_nx == CNT_DONE) begin
                     state_nx = IDLE;
                     cnt_nx   = '0;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
         if (accept) begin
            state_nx = HELD;
            cnt_nx   = '0;
         end
      end
   end

   always_comb begin
      key_down = (state == HELD) || (state == RELEASE);
   end

`ifdef SM_KEYPAD_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_cnt;
   logic [REP_W-1:0] rep_inc;
   logic [REP_W-1:0] rep_goal;
   logic             rep_first;
   logic             rep_step;

   // Only frames that stay in HELD advance the count; RELEASE leaves it frozen.
   always_comb begin
      rep_step = frame_end && (state == HELD) && (state_nx == HELD);
      rep_inc  = rep_cnt + REP_W'(1);
      rep_goal = rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
      rep_fire = rep_step && (rep_inc == rep_goal);
   end

   always_ff @(posedge clkIn) begin
      if (rst) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else if (accept) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (rep_step) begin
         if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_inc;
         end
      end else if (frame_end && state_nx == IDLE) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

endmodule
